shot_plotter: RTL and testbench



---
 rtl/shot_plotter.sv | 178 +++++++++++++++++
 tb/tb_shot_plotter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/shot_plotter.sv
// Bullet sprite plotter: erases the previously drawn sprite, then draws the new
// one, emitting one pixel write per clock to the VGA adapter.
module shot_plotter #(
  parameter int SPRITE_W = 2,
  parameter int SPRITE_H = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       drawEn,
  input  logic [7:0] bulletX,
  input  logic [6:0] bulletY,
  input  logic [2:0] colour,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] vgaColour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_dx, w_dx_nxt;
  logic [2:0] r_dy, w_dy_nxt;
  logic [7:0] r_cur_x, w_cur_x_nxt, r_old_x, w_old_x_nxt, r_pend_x, w_pend_x_nxt;
  logic [6:0] r_cur_y, w_cur_y_nxt, r_old_y, w_old_y_nxt, r_pend_y, w_pend_y_nxt;
  logic [2:0] r_cur_c, w_cur_c_nxt, r_pend_c, w_pend_c_nxt;
  logic       r_old_valid, w_old_valid_nxt, r_pending, w_pending_nxt;
  logic       w_last;

  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_vga_c;
  logic       r_plot;

  logic [7:0] w_base_x;
  logic [6:0] w_base_y;
  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;
  logic       w_pix_on, w_plot_nxt;
  logic [2:0] w_colour_nxt;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_dx_nxt        = r_dx;
    w_dy_nxt        = r_dy;
    w_cur_x_nxt     = r_cur_x;
    w_cur_y_nxt     = r_cur_y;
    w_cur_c_nxt     = r_cur_c;
    w_old_x_nxt     = r_old_x;
    w_old_y_nxt     = r_old_y;
    w_old_valid_nxt = r_old_valid;
    w_pend_x_nxt    = r_pend_x;
    w_pend_y_nxt    = r_pend_y;
    w_pend_c_nxt    = r_pend_c;
    w_pending_nxt   = r_pending;
    w_last          = (r_dx == 2'(SPRITE_W - 1)) && (r_dy == 3'(SPRITE_H - 1));

    case (r_state)
      IDLE: begin
        if (drawEn) begin
          w_cur_x_nxt = bulletX;
          w_cur_y_nxt = bulletY;
          w_cur_c_nxt = colour;
          w_dx_nxt    = '0;
          w_dy_nxt    = '0;
          w_state_nxt = r_old_valid ? ERASE : DRAW;
        end
      end
      ERASE, DRAW: begin
        if (w_last) begin
          w_dx_nxt    = '0;
          w_dy_nxt    = '0;
          w_state_nxt = (r_state == ERASE) ? DRAW : DONE;
        end else if (r_dx == 2'(SPRITE_W - 1)) begin
          w_dx_nxt = '0;
          w_dy_nxt = r_dy + 3'd1;
        end else begin
          w_dx_nxt = r_dx + 2'd1;
        end
      end
      DONE: begin
        w_old_x_nxt     = r_cur_x;
        w_old_y_nxt     = r_cur_y;
        w_old_valid_nxt = |r_cur_c;
        if (r_pending) begin
          w_cur_x_nxt   = r_pend_x;
          w_cur_y_nxt   = r_pend_y;
          w_cur_c_nxt   = r_pend_c;
          w_pending_nxt = 1'b0;
          w_dx_nxt      = '0;
          w_dy_nxt      = '0;
          w_state_nxt   = (|r_cur_c) ? ERASE : DRAW;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A request arriving in DONE overrides the pending-clear above: it queues
    // behind the job being launched now.
    if (drawEn && (r_state != IDLE)) begin
      w_pend_x_nxt  = bulletX;
      w_pend_y_nxt  = bulletY;
      w_pend_c_nxt  = colour;
      w_pending_nxt = 1'b1;
    end
  end

  // Pixel outputs are computed from next-cycle state so they line up with it.
  always_comb begin
    w_base_x     = (w_state_nxt == ERASE) ? w_old_x_nxt : w_cur_x_nxt;
    w_base_y     = (w_state_nxt == ERASE) ? w_old_y_nxt : w_cur_y_nxt;
    w_sum_x      = {1'b0, w_base_x} + 9'(w_dx_nxt);
    w_sum_y      = {1'b0, w_base_y} + 8'(w_dy_nxt);
    w_pix_on     = (w_state_nxt == ERASE) || (w_state_nxt == DRAW);
    w_plot_nxt   = w_pix_on && (w_sum_x < 9'(SCREEN_W)) && (w_sum_y < 8'(SCREEN_H));
    w_colour_nxt = (w_plot_nxt && (w_state_nxt == DRAW)) ? w_cur_c_nxt : 3'b000;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the sprite/request data registers are cleared too; they are small
  // flops, not a memory, so a full reset costs nothing and keeps traces clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dx        <= '0;
      r_dy        <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_cur_c     <= '0;
      r_old_x     <= '0;
      r_old_y     <= '0;
      r_old_valid <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_c    <= '0;
      r_pending   <= 1'b0;
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_c     <= '0;
      r_plot      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_cur_x     <= w_cur_x_nxt;
      r_cur_y     <= w_cur_y_nxt;
      r_cur_c     <= w_cur_c_nxt;
      r_old_x     <= w_old_x_nxt;
      r_old_y     <= w_old_y_nxt;
      r_old_valid <= w_old_valid_nxt;
      r_pend_x    <= w_pend_x_nxt;
      r_pend_y    <= w_pend_y_nxt;
      r_pend_c    <= w_pend_c_nxt;
      r_pending   <= w_pending_nxt;
      r_vga_x     <= w_sum_x[7:0];
      r_vga_y     <= w_sum_y[6:0];
      r_vga_c     <= w_colour_nxt;
      r_plot      <= w_plot_nxt;
    end
  end

  assign vgaX      = r_vga_x;
  assign vgaY      = r_vga_y;
  assign vgaColour = r_vga_c;
  assign plot      = r_plot;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_shot_plotter.sv
// Self-checking bench for shot_plotter: a job-level model expands each request
// into its expected per-cycle pixel stream and compares it cycle by cycle.
module tb_shot_plotter;

  localparam int SW = 2;
  localparam int SH = 4;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  logic       clk = 1'b0;
  logic       reset, drawEn;
  logic [7:0] bulletX;
  logic [6:0] bulletY;
  logic [2:0] colour;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] vgaColour;
  logic       plot, busy, done;

  shot_plotter #(.SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(SCR_W), .SCREEN_H(SCR_H)) dut (
    .clk(clk), .reset(reset), .drawEn(drawEn), .bulletX(bulletX), .bulletY(bulletY),
    .colour(colour), .vgaX(vgaX), .vgaY(vgaY), .vgaColour(vgaColour), .plot(plot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_plots = 0;
  int n_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: one cycle of expected activity per queue entry.
  typedef enum int {K_IDLE, K_PIX, K_DONE} kind_t;
  typedef struct {
    kind_t kind;
    int    x;
    int    y;
    int    c;
    int    p;
  } ent_t;

  ent_t q[$];
  ent_t disp;
  int   m_old_x, m_old_y, m_job_x, m_job_y, m_job_c;
  int   m_pend_x, m_pend_y, m_pend_c;
  bit   m_old_v, m_pend_v;

  function automatic ent_t pixel(int bx, int by, int dx, int dy, int c);
    ent_t e;
    int   sx = bx + dx;
    int   sy = by + dy;
    e.kind = K_PIX;
    e.p    = (sx < SCR_W && sy < SCR_H) ? 1 : 0;
    e.x    = sx % 256;
    e.y    = sy % 128;
    e.c    = e.p ? c : 0;
    return e;
  endfunction

  function automatic void gen_job(int x, int y, int c);
    ent_t d;
    m_job_x = x;
    m_job_y = y;
    m_job_c = c;
    if (m_old_v)
      for (int dy = 0; dy < SH; dy++)
        for (int dx = 0; dx < SW; dx++) q.push_back(pixel(m_old_x, m_old_y, dx, dy, 0));
    for (int dy = 0; dy < SH; dy++)
      for (int dx = 0; dx < SW; dx++) q.push_back(pixel(x, y, dx, dy, c));
    d = '{K_DONE, 0, 0, 0, 0};
    q.push_back(d);
  endfunction

  function automatic void model_step(bit rst, bit en, int x, int y, int c);
    if (rst) begin
      q.delete();
      m_old_v  = 0;
      m_pend_v = 0;
      disp     = '{K_IDLE, 0, 0, 0, 0};
      return;
    end
    if (disp.kind == K_DONE) begin
      m_old_x = m_job_x;
      m_old_y = m_job_y;
      m_old_v = (m_job_c != 0);
      if (m_pend_v) begin
        m_pend_v = 0;
        gen_job(m_pend_x, m_pend_y, m_pend_c);
      end
    end
    if (en) begin
      if (disp.kind != K_IDLE) begin
        m_pend_x = x;
        m_pend_y = y;
        m_pend_c = c;
        m_pend_v = 1;
      end else begin
        gen_job(x, y, c);
      end
    end
    if (q.size() > 0) disp = q.pop_front();
    else disp = '{K_IDLE, 0, 0, 0, 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(reset, drawEn, int'(bulletX), int'(bulletY), int'(colour));
    #1;
    check("busy", 32'(busy), 32'(disp.kind != K_IDLE));
    check("done", 32'(done), 32'(disp.kind == K_DONE));
    check("plot", 32'(plot), 32'(disp.kind == K_PIX && disp.p != 0));
    check("colour", 32'(vgaColour), 32'(disp.kind == K_PIX ? disp.c : 0));
    if (disp.kind == K_PIX) begin
      check("vgaX", 32'(vgaX), 32'(disp.x));
      check("vgaY", 32'(vgaY), 32'(disp.y));
    end
    if (plot) n_plots++;
    if (done) n_done++;
  endtask

  task automatic set_req(input int x, input int y, input int c);
    drawEn  = 1'b1;
    bulletX = 8'(x);
    bulletY = 7'(y);
    colour  = 3'(c);
  endtask

  // Issue one request from IDLE and measure cycles until done (t+1 == 1).
  task automatic request_lat(input string tag, input int x, input int y, input int c,
                             input int exp_lat);
    int n;
    n_plots = 0;
    set_req(x, y, c);
    tick();
    drawEn = 1'b0;
    n = 1;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_lat));
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    disp    = '{K_IDLE, 0, 0, 0, 0};
    reset   = 1'b1;
    drawEn  = 1'b0;
    bulletX = '0;
    bulletY = '0;
    colour  = '0;
    tick();
    tick();
    check("rst_vgaX", 32'(vgaX), 32'd0);
    check("rst_vgaY", 32'(vgaY), 32'd0);
    reset = 1'b0;
    tick();

    request_lat("lat_first", 10, 100, 7, 9);
    request_lat("lat_erase", 10, 95, 7, 17);
    request_lat("lat_black", 40, 40, 0, 17);
    request_lat("lat_clip", 159, 118, 7, 9);
    check("clip_plots", 32'(n_plots), 32'd2);

    // Two requests while busy: only the newest is serviced, with no IDLE gap.
    n_done = 0;
    set_req(50, 60, 5);
    tick();
    drawEn = 1'b0;
    repeat (3) tick();
    set_req(20, 50, 3);
    tick();
    drawEn = 1'b0;
    repeat (2) tick();
    set_req(30, 40, 6);
    tick();
    drawEn = 1'b0;
    drain();
    check("pend_jobs", 32'(n_done), 32'd2);

    // Reset in the middle of DRAW abandons the job and forgets the old sprite.
    set_req(70, 70, 2);
    tick();
    drawEn = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_busy", 32'(busy), 32'd0);
    reset  = 1'b0;
    n_done = 0;
    repeat (5) tick();
    check("rst_no_done", 32'(n_done), 32'd0);
    request_lat("lat_after_rst", 5, 5, 1, 9);

    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 499) == 0);
      drawEn  = ($urandom_range(0, 7) == 0);
      bulletX = 8'($urandom_range(0, 255));
      bulletY = 7'($urandom_range(0, 127));
      colour  = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      tick();
    end
    reset  = 1'b0;
    drawEn = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
